// File: rtl/blink_fill_engine.sv
`default_nettype none
// ============================================================================
// Module      : blink_fill_engine
// Description : Range set/clear/toggle writer for the 1-bit-per-char blink RAM.
//               Optional macro BLINK_FILL_CLIP_EN clips ranges that run past
//               the last character instead of rejecting them.
// Revision    : 1.0 - initial release
// ============================================================================
module blink_fill_engine #(
    parameter  int CHAR_NUM  = 2400,
    parameter  int RAM_DEPTH = 300,
    localparam int ADDR_W    = $clog2(RAM_DEPTH)
) (
    input  logic              sysclk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [11:0]       cmd_start_i,
    input  logic [11:0]       cmd_len_i,
    input  logic [1:0]        cmd_op_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_data_o,
    output logic              ram_wren_o,
    input  logic [7:0]        ram_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [1:0]  OP_CLR    = 2'b00;
    localparam logic [1:0]  OP_SET    = 2'b01;
    localparam logic [1:0]  OP_TGL    = 2'b10;
    localparam logic [1:0]  OP_RSV    = 2'b11;
    localparam logic [12:0] CHAR_LIM  = 13'(CHAR_NUM);
    localparam logic [11:0] LAST_CHAR = 12'(CHAR_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WT   = 3'd2,
        S_WR   = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [ADDR_W-1:0] cur_byte;
    logic [ADDR_W-1:0] first_byte;
    logic [ADDR_W-1:0] last_byte;
    logic [2:0]        start_bit;
    logic [2:0]        end_bit;
    logic [1:0]        op;
    logic              err_flag;

    // Bits of one byte that fall inside [start,end]; only the first and
    // last byte of a range can be partial.
    function automatic logic [7:0] byte_mask(input logic       is_first,
                                             input logic       is_last,
                                             input logic [2:0] lo,
                                             input logic [2:0] hi);
        logic [7:0] lo_m;
        logic [7:0] hi_m;
        lo_m = is_first ? (8'hFF << lo) : 8'hFF;
        hi_m = is_last  ? (8'hFF >> (3'd7 - hi)) : 8'hFF;
        return lo_m & hi_m;
    endfunction

    function automatic logic needs_rmw(input logic [7:0] mask, input logic [1:0] opc);
        return (mask != 8'hFF) || (opc == OP_TGL);
    endfunction

    // ---------------- command decode ----------------
    logic [12:0] cmd_end;
    logic [11:0] eff_end;
    logic        len_zero;
    logic        op_bad;
    logic        start_bad;
    logic        end_bad;
    logic        cmd_err;
    logic        cmd_noop;
    logic [7:0]  first_mask;
    logic        first_rmw;

    assign cmd_end   = {1'b0, cmd_start_i} + {1'b0, cmd_len_i} - 13'd1;
    assign len_zero  = (cmd_len_i == 12'd0);
    assign op_bad    = (cmd_op_i == OP_RSV);
    assign start_bad = ({1'b0, cmd_start_i} >= CHAR_LIM);
    assign end_bad   = !len_zero && (cmd_end >= CHAR_LIM);

`ifdef BLINK_FILL_CLIP_EN
    assign eff_end  = end_bad ? LAST_CHAR : cmd_end[11:0];
    assign cmd_err  = op_bad || start_bad;
    assign cmd_noop = cmd_err || len_zero;
`else
    assign eff_end  = cmd_end[11:0];
    assign cmd_err  = op_bad || start_bad || end_bad;
    assign cmd_noop = cmd_err || len_zero;
`endif

    assign first_mask = byte_mask(1'b1, cmd_start_i[11:3] == eff_end[11:3],
                                  cmd_start_i[2:0], eff_end[2:0]);
    assign first_rmw  = needs_rmw(first_mask, cmd_op_i);

    // ---------------- byte loop datapath ----------------
    logic [ADDR_W-1:0] nxt_byte;
    logic [7:0]        cur_mask;
    logic [7:0]        nxt_mask;
    logic              nxt_rmw;
    logic [7:0]        new_data;

    assign nxt_byte = cur_byte + 1'b1;
    assign cur_mask = byte_mask(cur_byte == first_byte, cur_byte == last_byte,
                                start_bit, end_bit);
    assign nxt_mask = byte_mask(1'b0, nxt_byte == last_byte, start_bit, end_bit);
    assign nxt_rmw  = needs_rmw(nxt_mask, op);

    // Full-byte set/clear never reads, but the formulas still give FF/00
    // regardless of whatever is on ram_data_i.
    always_comb begin
        new_data = ram_data_i;
        case (op)
            OP_CLR:  new_data = ram_data_i & ~cur_mask;
            OP_SET:  new_data = ram_data_i | cur_mask;
            OP_TGL:  new_data = ram_data_i ^ cur_mask;
            default: new_data = ram_data_i;
        endcase
    end

    assign ram_addr_o = cur_byte;

    // ---------------- FSM ----------------
    always_ff @(posedge sysclk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= S_IDLE;
            cur_byte   <= '0;
            first_byte <= '0;
            last_byte  <= '0;
            start_bit  <= '0;
            end_bit    <= '0;
            op         <= OP_CLR;
            err_flag   <= 1'b0;
        end else begin
            state <= state_d;
            if (state == S_IDLE && cmd_valid_i) begin
                err_flag <= cmd_err;
                if (!cmd_noop) begin
                    cur_byte   <= ADDR_W'(cmd_start_i[11:3]);
                    first_byte <= ADDR_W'(cmd_start_i[11:3]);
                    last_byte  <= ADDR_W'(eff_end[11:3]);
                    start_bit  <= cmd_start_i[2:0];
                    end_bit    <= eff_end[2:0];
                    op         <= cmd_op_i;
                end
            end else if (state == S_WR && cur_byte != last_byte) begin
                cur_byte <= nxt_byte;
            end
        end
    end

    always_comb begin
        state_d     = state;
        cmd_ready_o = 1'b0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        err_o       = 1'b0;
        ram_wren_o  = 1'b0;
        ram_data_o  = 8'h00;
        unique case (state)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (cmd_valid_i) begin
                    if (cmd_noop)       state_d = S_FIN;
                    else if (first_rmw) state_d = S_RD;
                    else                state_d = S_WR;
                end
            end
            S_RD: state_d = S_WT;
            S_WT: state_d = S_WR;
            S_WR: begin
                ram_wren_o = 1'b1;
                ram_data_o = new_data;
                if (cur_byte == last_byte) state_d = S_FIN;
                else if (nxt_rmw)          state_d = S_RD;
                else                       state_d = S_WR;
            end
            S_FIN: begin
                done_o  = 1'b1;
                err_o   = err_flag;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_blink_fill_engine.sv
`default_nettype none
// Testbench for blink_fill_engine: random range commands against a per-character
// reference model, with a queue scoreboard checking every RAM write and completion.
module tb_blink_fill_engine;

    localparam int CHAR_NUM  = 2400;
    localparam int RAM_DEPTH = 300;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [11:0] cmd_start = '0;
    logic [11:0] cmd_len = '0;
    logic [1:0]  cmd_op = '0;
    logic [8:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_wren;
    logic [7:0]  ram_rdata;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    blink_fill_engine #(.CHAR_NUM(CHAR_NUM), .RAM_DEPTH(RAM_DEPTH)) dut (
        .sysclk_i    (clk),
        .rst_ni      (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_start_i (cmd_start),
        .cmd_len_i   (cmd_len),
        .cmd_op_i    (cmd_op),
        .ram_addr_o  (ram_addr),
        .ram_data_o  (ram_wdata),
        .ram_wren_o  (ram_wren),
        .ram_data_i  (ram_rdata),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    // Blink RAM with 2-cycle read latency
    logic [7:0] mem [RAM_DEPTH] = '{default: 8'h00};
    logic [7:0] rd_pipe1 = 8'h00;
    logic [7:0] rd_pipe2 = 8'h00;
    assign ram_rdata = rd_pipe2;
    always @(posedge clk) begin
        if (ram_wren && ram_addr < 9'(RAM_DEPTH)) mem[ram_addr] <= ram_wdata;
        rd_pipe1 <= (ram_addr < 9'(RAM_DEPTH)) ? mem[ram_addr] : 8'h00;
        rd_pipe2 <= rd_pipe1;
    end

    typedef struct { int addr; int data; } wr_t;
    typedef struct { bit err; int cycles; } dn_t;

    wr_t wq[$];
    dn_t dq[$];
    bit  model_bits [CHAR_NUM];
    int  vectors = 0;
    int  miscompares = 0;
    bit  mon_en = 0;
    int  busy_cnt = 0;

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference: apply the op per character, then report the packed bytes touched.
    task automatic model_cmd(input int s, input int l, input int op);
        int e;
        bit e_err;
        bit noop;
        int cyc;
        wr_t w;
        dn_t d;
        e = s + l - 1;
        e_err = 0;
        noop = 0;
        if (op == 3)              begin e_err = 1; noop = 1; end
        else if (s >= CHAR_NUM)   begin e_err = 1; noop = 1; end
        else if (l == 0)          noop = 1;
        else if (e >= CHAR_NUM) begin
`ifdef BLINK_FILL_CLIP_EN
            e = CHAR_NUM - 1;
`else
            e_err = 1;
            noop = 1;
`endif
        end
        cyc = 1;
        if (!noop) begin
            for (int c = s; c <= e; c++) begin
                if (op == 0)      model_bits[c] = 1'b0;
                else if (op == 1) model_bits[c] = 1'b1;
                else              model_bits[c] = ~model_bits[c];
            end
            for (int b = s / 8; b <= e / 8; b++) begin
                int in_cnt = 0;
                int val = 0;
                for (int k = 0; k < 8; k++) begin
                    if (b * 8 + k >= s && b * 8 + k <= e) in_cnt++;
                    if (model_bits[b * 8 + k]) val = val | (1 << k);
                end
                w.addr = b;
                w.data = val;
                wq.push_back(w);
                cyc += (in_cnt == 8 && op != 2) ? 1 : 3;
            end
        end
        d.err = e_err;
        d.cycles = cyc;
        dq.push_back(d);
    endtask

    task automatic run_monitor();
        wr_t w;
        dn_t d;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (busy) busy_cnt++;
                if (ram_wren) begin
                    vectors++;
                    if (wq.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_write: got addr=%0d data=%02h, expected no write",
                                 ram_addr, ram_wdata);
                    end else begin
                        w = wq.pop_front();
                        if (int'(ram_addr) != w.addr || int'(ram_wdata) != w.data) begin
                            miscompares++;
                            $display("FAIL write: got addr=%0d data=%02h, expected addr=%0d data=%02h",
                                     ram_addr, ram_wdata, w.addr, w.data);
                        end
                    end
                end
                if (done) begin
                    vectors++;
                    if (dq.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_done: got done=1 err=%0b, expected no completion", err);
                    end else begin
                        d = dq.pop_front();
                        if (err != d.err || busy_cnt != d.cycles || wq.size() != 0) begin
                            miscompares++;
                            $display("FAIL done: got err=%0b busy=%0d pend_wr=%0d, expected err=%0b busy=%0d pend_wr=0",
                                     err, busy_cnt, wq.size(), d.err, d.cycles);
                        end
                    end
                    busy_cnt = 0;
                end else if (err) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL err_without_done: got err=1, expected 0");
                end
            end
        end
    endtask

    task automatic issue(input int s, input int l, input int op);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 5000) begin
            n++;
            @(negedge clk);
        end
        if (!cmd_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: got ready=0 after %0d cycles, expected 1", n);
            return;
        end
        model_cmd(s, l, op);
        cmd_start = s[11:0];
        cmd_len   = l[11:0];
        cmd_op    = op[1:0];
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, int'(cmd_ready), 1);
        check({tag, "_busy"},  int'(busy), 0);
        check({tag, "_done"},  int'(done), 0);
        check({tag, "_err"},   int'(err), 0);
        check({tag, "_wren"},  int'(ram_wren), 0);
        check({tag, "_addr"},  int'(ram_addr), 0);
        check({tag, "_data"},  int'(ram_wdata), 0);
    endtask

    initial begin
        int n;
        fork
            run_monitor();
        join_none

        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        mon_en = 1'b1;

        issue(3, 7, 1);          // two partial bytes: F8 @0, 03 @1
        issue(0, 8, 1);          // full byte, write only
        issue(2399, 1, 1);       // 80 @299
        issue(2399, 1, 2);       // toggle back to 00
        issue(2395, 10, 1);      // overrun range
        issue(40, 0, 0);         // zero length
        issue(0, 5, 3);          // reserved op
        issue(4095, 3, 1);       // start beyond screen
        issue(16, 200, 0);       // 25 full bytes
        cmd_start = 12'd100;     // held while busy, must be ignored
        cmd_len   = 12'd50;
        cmd_op    = 2'd1;
        cmd_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 cmd_valid = 1'b0;

        // Reset in the middle of a long toggle
        issue(5, 800, 2);
        repeat (20) @(posedge clk);
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        repeat (3) begin
            @(negedge clk);
            check("rst_hold_wren", int'(ram_wren), 0);
        end
        wq.delete();
        dq.delete();
        busy_cnt = 0;
        for (int c = 0; c < CHAR_NUM; c++) model_bits[c] = mem[c / 8][c % 8];
        rst_n = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 200; i++) begin
            int s, l, op, r;
            r  = $urandom_range(0, 99);
            op = (r < 6) ? 3 : int'($urandom_range(0, 2));
            r  = $urandom_range(0, 99);
            if (r < 8)       s = $urandom_range(CHAR_NUM, 4095);
            else if (r < 20) s = $urandom_range(CHAR_NUM - 40, CHAR_NUM - 1);
            else             s = $urandom_range(0, CHAR_NUM - 1);
            r = $urandom_range(0, 99);
            if (r < 8)       l = 0;
            else if (r < 15) l = $urandom_range(0, 4095);
            else             l = $urandom_range(1, 70);
            if (l == 0 && s >= CHAR_NUM) s = s - CHAR_NUM;
            issue(s, l, op);
        end

        n = 0;
        while (dq.size() != 0 && n < 20000) begin
            n++;
            @(negedge clk);
        end
        if (dq.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending completions, expected 0", dq.size());
        end
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
